latch_bus_sequencer: RTL and testbench
======================================

Name: latch_bus_sequencer

Overview:
- Sequences one shared bank of 74S373 transparent latches and its downstream 74S174 capture register, and arbitrates the bank among NREQ requesters.
- The granted requester's data is steered to the latch inputs. The block then walks latch-open, latch-hold and drive phases, and pulses the register clock-enable.
- Sits between requester logic and the part_74S373/part_74S174 instances on a shared CADR-style bus.

Parameters:
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: data width of the latch bank.
- SETUP_CYC, 2: cycles the latch is transparent (HOLD_N=1) before closing (1..15).
- DRIVE_CYC, 3: cycles OENB_N is low driving the bus (1..15).

Ports:
- clock, in, 1: single system clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- req, in, NREQ: level request per requester; held until done.
- req_data, in, NREQ*WIDTH: requester i data at bits [i*WIDTH +: WIDTH].
- gnt, out, NREQ: one-hot grant.
- done, out, NREQ: one-cycle completion pulse to the owner.
- latch_d, out, WIDTH: to the 74S373 I inputs.
- latch_hold_n, out, 1: to the 74S373 HOLD_N (1 = transparent).
- latch_oenb_n, out, 1: to the 74S373 OENB_N (0 = drive).
- reg_clk_en, out, 1: capture enable for the 74S174 stage.
- reg_clr_n, out, 1: to the 74S174 CLR_N.
- busy, out, 1: high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset applies at a clock edge while reset=1.
- Reset values:
  - state IDLE, gnt=0, done=0, latch_d=0;
  - latch_hold_n=0, latch_oenb_n=1;
  - reg_clk_en=0, reg_clr_n=0, busy=0;
  - round-robin pointer=0.
- reg_clr_n rises to 1 on the first edge with reset=0.
- States and transitions:
  - IDLE: if any req bit is set, pick a winner and go to SETUP. Next cycle, gnt=onehot(winner), latch_hold_n=1, latch_d=req_data[winner], busy=1. Latency from req to gnt is 1 cycle.
  - SETUP: latch_hold_n=1 for SETUP_CYC cycles (down-counter), then go to LATCH.
  - LATCH: 1 cycle, latch_hold_n=0. latch_d stays stable through this cycle, then goes to DRIVE.
  - DRIVE: latch_oenb_n=0 for DRIVE_CYC cycles. reg_clk_en=1 in the last DRIVE cycle only. Then go to RELEASE.
  - RELEASE: 1 cycle. latch_oenb_n=1, done[winner]=1, gnt still asserted. Pointer becomes winner+1 mod NREQ. Then go to IDLE.
  - On entering IDLE, gnt=0 and busy=0.
- Transaction length: SETUP_CYC+DRIVE_CYC+3 cycles from gnt to the next possible gnt.
- Arbitration: round-robin. Search starts at the pointer and the first set req wins, so simultaneous requests resolve relative to the pointer.
- A requester that re-asserts immediately after done loses to any other pending requester.
- req is sampled only in IDLE. Deasserting req mid-transaction has no effect; the transaction completes and done still pulses.
- req_data is sampled once, at the IDLE→SETUP edge, and latch_d is held from an internal register.
- latch_hold_n and latch_oenb_n are never both active (1 and 0) in the same cycle.
- Reset mid-transaction: immediate return to reset values next edge, with no done pulse.

Optional Feature:
- Macro: LATCH_SEQ_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is removed and the RELEASE rotation does not occur.
- Undefined: round-robin as above.

Decomposition:
- Package latch_seq_pkg holds:
  - state encoding constants: IDLE=3'd0, SETUP=3'd1, LATCH=3'd2, DRIVE=3'd3, RELEASE=3'd4;
  - phase-counter width constant CNT_W=4.
- Sub-module rr_pick (NREQ): combinational req/pointer → one-hot winner plus index. The macro selects its fixed-priority variant.
- The FSM, counter and data register stay in the top module.

Test Plan (NREQ=4, WIDTH=8, SETUP_CYC=2, DRIVE_CYC=3):
- Reset: hold reset=1 for 2 edges → gnt=0, latch_hold_n=0, latch_oenb_n=1, reg_clr_n=0. After the first edge with reset=0, reg_clr_n=1.
- Single request: req=4'b0010, data1=8'hA5 at cycle 0 →
  - cycles 1–2: gnt=0010, hold_n=1, latch_d=A5;
  - cycle 3: hold_n=0;
  - cycles 4–6: oenb_n=0, with reg_clk_en=1 only at cycle 6;
  - cycle 7: done=0010;
  - cycle 8: busy=0.
- Contention: req=4'b1011 held continuously → grant order 0,1,3,0, with gnts 8 cycles apart. With LATCH_SEQ_FIXED_PRIO_EN defined → 0,0,0.
- Early drop: req[2] deasserted in SETUP, data 8'h3C → full sequence completes, latch_d=3C through LATCH, done[2] pulses.
- Data stability: change req_data[1] from A5 to FF during SETUP → latch_d stays A5.
- Mid-operation reset: assert reset during DRIVE → next edge oenb_n=1, hold_n=0, gnt=0, no done pulse. A re-request starts cleanly with pointer=0.

Source files
------------

// File: rtl/latch_seq_pkg.sv
// Shared types and constants for the latch bank sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package latch_seq_pkg;

  // Sequencer phases, in the order a transaction walks them.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    LATCH   = 3'd2,
    DRIVE   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  // Width of the phase down-counter; covers SETUP_CYC/DRIVE_CYC up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Winner picker: one-hot grant plus index from the request vector.
// Latency: combinational. Backpressure: none; result valid whenever any req is set.
// LATCH_SEQ_FIXED_PRIO_EN selects lowest-index-wins and drops the pointer input.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifndef LATCH_SEQ_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx
);

`ifdef LATCH_SEQ_FIXED_PRIO_EN

  // Lowest set index wins; descending scan so the last hit is the lowest.
  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
    onehot = (|req) ? (NREQ'(1) << idx) : '0;
  end

`else

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  ofs;
  logic [IDX_W:0]    sum;

  // Rotate requests so the pointer lands at bit 0, take the first set bit,
  // then map the rotated offset back to an absolute requester index.
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NREQ-1:0];
    ofs = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) ofs = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, ofs};
    if (sum >= (IDX_W + 1)'(NREQ)) sum = sum - (IDX_W + 1)'(NREQ);
    idx    = sum[IDX_W-1:0];
    onehot = (|req) ? (NREQ'(1) << idx) : '0;
  end

`endif

endmodule

// File: rtl/latch_bus_sequencer.sv
// Arbitrates one 74S373 latch bank among NREQ requesters and sequences open/hold/drive, then pulses the 74S174 enable.
// Latency: req to gnt 1 cycle; SETUP_CYC+DRIVE_CYC+3 cycles from gnt to next possible gnt. All outputs registered.
// Backpressure: req is a level held until done; only sampled in IDLE. LATCH_SEQ_FIXED_PRIO_EN = fixed priority.
module latch_bus_sequencer
  import latch_seq_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 2,
  parameter int DRIVE_CYC = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      latch_d,
  output logic                  latch_hold_n,
  output logic                  latch_oenb_n,
  output logic                  reg_clk_en,
  output logic                  reg_clr_n,
  output logic                  busy
);

  localparam int IDX_W = $clog2(NREQ);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NREQ-1:0]    gnt_nxt;
  logic [WIDTH-1:0]   latch_d_nxt;
  logic [NREQ-1:0]    pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_req;

  assign any_req = |req;

`ifdef LATCH_SEQ_FIXED_PRIO_EN

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

`else

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // Remember the winner; rotate the pointer past it when the transaction releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      win <= '0;
    end else if (state == IDLE && any_req) begin
      win <= pick_idx;
    end else if (state == RELEASE) begin
      ptr <= (win == IDX_W'(NREQ - 1)) ? '0 : win + IDX_W'(1);
    end
  end

`endif

  // Next-state, phase counter, grant and data capture.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gnt_nxt     = gnt;
    latch_d_nxt = latch_d;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt   = SETUP;
          cnt_nxt     = CNT_W'(SETUP_CYC - 1);
          gnt_nxt     = pick_oh;
          latch_d_nxt = req_data[int'(pick_idx)*WIDTH +: WIDTH];
        end
      end
      SETUP: begin
        if (cnt == '0) state_nxt = LATCH;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      LATCH: begin
        state_nxt = DRIVE;
        cnt_nxt   = CNT_W'(DRIVE_CYC - 1);
      end
      DRIVE: begin
        if (cnt == '0) state_nxt = RELEASE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      RELEASE: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  // Register state and derive every output from the state being entered,
  // so the pins change on the same edge as the phase and never glitch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt          <= '0;
      done         <= '0;
      latch_d      <= '0;
      latch_hold_n <= 1'b0;
      latch_oenb_n <= 1'b1;
      reg_clk_en   <= 1'b0;
      reg_clr_n    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      gnt          <= gnt_nxt;
      latch_d      <= latch_d_nxt;
      done         <= (state_nxt == RELEASE) ? gnt_nxt : '0;
      latch_hold_n <= (state_nxt == SETUP);
      latch_oenb_n <= (state_nxt != DRIVE);
      reg_clk_en   <= (state_nxt == DRIVE) && (cnt_nxt == '0);
      reg_clr_n    <= 1'b1;
      busy         <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_latch_bus_sequencer.sv
// Bench for latch_bus_sequencer: directed test-plan steps plus random traffic against a transaction-level model.
// Latency: n/a. Backpressure: n/a.
// Honours LATCH_SEQ_FIXED_PRIO_EN in its reference arbitration.
module tb_latch_bus_sequencer;
  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt, done;
  logic [W-1:0]   latch_d;
  logic           latch_hold_n, latch_oenb_n, reg_clk_en, reg_clr_n, busy;

  latch_bus_sequencer #(.NREQ(N), .WIDTH(W), .SETUP_CYC(S), .DRIVE_CYC(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .latch_d      (latch_d),
    .latch_hold_n (latch_hold_n),
    .latch_oenb_n (latch_oenb_n),
    .reg_clk_en   (reg_clk_en),
    .reg_clr_n    (reg_clr_n),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int total  = 0;
  int passed = 0;

  // Transaction-level reference: t counts cycles since the grant edge.
  bit         m_busy = 0;
  int         m_t    = 0;
  int         m_win  = 0;
  int         m_ptr  = 0;
  logic [7:0] m_data = '0;
  bit         m_clr  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    int start;
`ifdef LATCH_SEQ_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_busy = 0; m_t = 0; m_ptr = 0; m_data = '0; m_clr = 0;
    end else begin
      m_clr = 1;
      if (!m_busy) begin
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_busy = 1; m_t = 1; m_win = w; m_data = req_data[w*W +: W];
        end
      end else begin
        m_t++;
        if (m_t == S + D + 3) begin
          m_busy = 0;
          m_ptr  = (m_win + 1) % N;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = m_busy ? N'(1 << m_win) : '0;
    chk("gnt",    gnt, eg);
    chk("done",   done, (m_busy && m_t == S + D + 2) ? eg : '0);
    chk("hold_n", latch_hold_n, m_busy && m_t <= S);
    chk("oenb_n", latch_oenb_n, !(m_busy && m_t >= S + 2 && m_t <= S + D + 1));
    chk("clk_en", reg_clk_en, m_busy && m_t == S + D + 1);
    chk("clr_n",  reg_clr_n, m_clr);
    chk("busy",   busy, m_busy);
    chk("latch_d", latch_d, m_data);
    chk("exclusive", latch_hold_n && !latch_oenb_n, 1'b0);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_all();
  endtask

  logic [N-1:0] prev_g;
  int           order[$];
  int           gcyc[$];
  int           exp_order[4];

  initial begin
    // Reset held for two edges.
    reset = 1'b1;
    step(); step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_hold_n", latch_hold_n, 1'b0);
    chk("rst_oenb_n", latch_oenb_n, 1'b1);
    chk("rst_clr_n", reg_clr_n, 1'b0);
    reset = 1'b0;
    step();
    chk("clr_n_rise", reg_clr_n, 1'b1);

    // Single request from requester 1, with a data change during SETUP.
    req = 4'b0010;
    req_data[15:8] = 8'hA5;
    for (int c = 1; c <= 8; c++) begin
      step();
      case (c)
        1: begin
          chk("single_gnt", gnt, 4'b0010);
          chk("single_d", latch_d, 8'hA5);
          req_data[15:8] = 8'hFF;
        end
        2: chk("stable_d_setup", latch_d, 8'hA5);
        3: begin
          chk("latch_hold_n", latch_hold_n, 1'b0);
          chk("stable_d_latch", latch_d, 8'hA5);
        end
        5: chk("drive_no_clk_en", reg_clk_en, 1'b0);
        6: begin
          chk("drive_clk_en", reg_clk_en, 1'b1);
          chk("drive_oenb_n", latch_oenb_n, 1'b0);
        end
        7: begin
          chk("single_done", done, 4'b0010);
          req = 4'b0000;
        end
        8: chk("single_idle", busy, 1'b0);
        default: ;
      endcase
    end

    // Early drop: requester 2 lets go during SETUP.
    req = 4'b0100;
    req_data[23:16] = 8'h3C;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c == 1) req = 4'b0000;
      if (c == 3) chk("drop_d_latch", latch_d, 8'h3C);
      if (c == 7) chk("drop_done", done, 4'b0100);
    end

    // Contention from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0;
    req = 4'b1011;
    prev_g = '0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (gnt != '0 && prev_g == '0) begin
        order.push_back(oh_idx(gnt));
        gcyc.push_back(c);
      end
      prev_g = gnt;
    end
`ifdef LATCH_SEQ_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 3, 0};
`endif
    chk("ctn_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++) begin
      chk($sformatf("ctn_order%0d", k), order[k], exp_order[k]);
      if (k > 0) chk($sformatf("ctn_gap%0d", k), gcyc[k] - gcyc[k-1], 8);
    end
    req = 4'b0000;
    for (int c = 0; c < 10; c++) step();

    // Reset during DRIVE, then a clean re-request.
    req = 4'b0100;
    for (int c = 1; c <= 5; c++) step();
    reset = 1'b1;
    step();
    chk("mrst_oenb_n", latch_oenb_n, 1'b1);
    chk("mrst_hold_n", latch_hold_n, 1'b0);
    chk("mrst_gnt", gnt, 4'b0000);
    chk("mrst_done", done, 4'b0000);
    reset = 1'b0;
    req = 4'b1010;
    step();
    chk("mrst_regnt", gnt, 4'b0010);
    req = 4'b0000;
    for (int c = 0; c < 10; c++) step();

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      req      = N'($urandom_range(0, 15));
      req_data = $urandom;
      reset    = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
